// File: rtl/clk_div_pkg.sv
// Shared types and constants for the runtime-programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_div_sched_core.sv
// Period counter, registered divided-clock level and edge strobes for clk_div_sched.
module clk_div_core #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  output logic             at_end,
  output logic             div_clk,
  output logic             rise_stb,
  output logic             fall_stb
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] half;

  assign half   = div >> 1;
  assign at_end = en && (cnt == div - CNT_W'(1));

  always_comb begin
    cnt_nxt = '0;
    if (en && !at_end) cnt_nxt = cnt + CNT_W'(1);
  end

  // Level and strobes are derived from the next count so they line up with cnt.
  // A ratio change only happens when cnt_nxt is 0, where neither depends on div.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt      <= '0;
      div_clk  <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      div_clk  <= (cnt_nxt >= half);
      rise_stb <= (cnt_nxt == half);
      fall_stb <= at_end;
    end
  end

endmodule

// File: rtl/clk_div_sched.sv
// Clock-divider controller: run/drain sequencing and ratio req/ack handshake.
module clk_div_sched #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             iRUN,
  input  logic             iDIV_REQ,
  input  logic [CNT_W-1:0] iDIV_VAL,
  output logic             oDIV_ACK,
  output logic             oDIV_ERR,
  output logic             oDIV_CLK,
  output logic             oRISE_STB,
  output logic             oFALL_STB,
  output logic             oBUSY,
  output logic [CNT_W-1:0] oCUR_DIV
);
  import clk_div_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] pending_div;
  logic             pending_valid;
  logic             at_end;
  logic             apply;
  logic             req_ok;
  logic             ack_q;
  logic             err_q;

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .en       (state != ST_IDLE),
    .div      (active_div),
    .at_end   (at_end),
    .div_clk  (oDIV_CLK),
    .rise_stb (oRISE_STB),
    .fall_stb (oFALL_STB)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (iRUN) state_nxt = ST_RUN;
      ST_RUN:   if (!iRUN) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (iRUN)        state_nxt = ST_RUN;
        else if (at_end) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign req_ok = iDIV_REQ && (iDIV_VAL >= CNT_W'(MIN_DIV));
  assign apply  = pending_valid && ((state == ST_IDLE) || at_end);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      active_div    <= CNT_W'(DEF_DIV);
      pending_div   <= '0;
      pending_valid <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= apply;
      err_q <= iDIV_REQ && !req_ok;
      if (apply) active_div <= pending_div;
      // A request in the apply cycle itself stays pending for the next boundary.
      if (req_ok) begin
        pending_div   <= iDIV_VAL;
        pending_valid <= 1'b1;
      end else if (apply) begin
        pending_valid <= 1'b0;
      end
    end
  end

  assign oDIV_ACK = ack_q;
  assign oDIV_ERR = err_q;
  assign oBUSY    = (state != ST_IDLE);
  assign oCUR_DIV = active_div;

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: expected per-cycle outputs are queued, then compared.
module tb_clk_div_sched;

  logic       CLK;
  logic       RST_N;
  logic       iRUN;
  logic       iDIV_REQ;
  logic [7:0] iDIV_VAL;
  logic       oDIV_ACK;
  logic       oDIV_ERR;
  logic       oDIV_CLK;
  logic       oRISE_STB;
  logic       oFALL_STB;
  logic       oBUSY;
  logic [7:0] oCUR_DIV;

  typedef struct packed {
    logic       clk;
    logic       rise;
    logic       fall;
    logic       ack;
    logic       err;
    logic       busy;
    logic [7:0] cur;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  string test_name = "none";

  clk_div_sched #(.CNT_W(8), .DEF_DIV(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .iRUN      (iRUN),
    .iDIV_REQ  (iDIV_REQ),
    .iDIV_VAL  (iDIV_VAL),
    .oDIV_ACK  (oDIV_ACK),
    .oDIV_ERR  (oDIV_ERR),
    .oDIV_CLK  (oDIV_CLK),
    .oRISE_STB (oRISE_STB),
    .oFALL_STB (oFALL_STB),
    .oBUSY     (oBUSY),
    .oCUR_DIV  (oCUR_DIV)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic exp_t actual();
    exp_t a;
    a = {oDIV_CLK, oRISE_STB, oFALL_STB, oDIV_ACK, oDIV_ERR, oBUSY, oCUR_DIV};
    return a;
  endfunction

  // One full period: low floor(d/2) cycles then high; strobes at the transitions.
  task automatic push_period(input int d, input bit first, input bit ack, input int unsigned err_mask);
    exp_t e;
    for (int i = 0; i < d; i++) begin
      e.clk  = (i >= d / 2);
      e.rise = (i == d / 2);
      e.fall = (i == 0) && !first;
      e.ack  = (i == 0) && ack;
      e.err  = err_mask[i];
      e.busy = 1'b1;
      e.cur  = 8'(d);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_idle(input bit fall, input bit ack, input int cur);
    exp_t e;
    e = '0;
    e.fall = fall;
    e.ack  = ack;
    e.cur  = 8'(cur);
    exp_q.push_back(e);
  endtask

  task automatic tick_check();
    exp_t a;
    exp_t e;
    @(posedge CLK);
    #1;
    a = actual();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s cycle %0d: no expected entry, got clk/rise/fall/ack/err/busy=%b cur=%0d",
               test_name, cyc, a[13:8], a.cur);
    end else begin
      e = exp_q.pop_front();
      if (a !== e)
        begin
          errors++;
          $display("FAIL %s cycle %0d: got clk/rise/fall/ack/err/busy=%b cur=%0d, want %b cur=%0d",
                   test_name, cyc, a[13:8], a.cur, e[13:8], e.cur);
        end
    end
    cyc++;
  endtask

  // Advance n cycles; after observing index i, drive stimulus for the next edge.
  task automatic run_n(input int n, input int r1, input logic [7:0] v1,
                       input int r2, input logic [7:0] v2, input int drop, input int raise);
    for (int i = 0; i < n; i++) begin
      tick_check();
      iDIV_REQ = 1'b0;
      if (i == r1) begin iDIV_REQ = 1'b1; iDIV_VAL = v1; end
      if (i == r2) begin iDIV_REQ = 1'b1; iDIV_VAL = v2; end
      if (i == drop)  iRUN = 1'b0;
      if (i == raise) iRUN = 1'b1;
    end
  endtask

  task automatic test_reset();
    exp_t a;
    test_name = "reset";
    RST_N = 1'b0; iRUN = 1'b0; iDIV_REQ = 1'b0; iDIV_VAL = '0;
    repeat (3) @(posedge CLK);
    #1;
    a = actual();
    checks++; if (a.clk  !== 1'b0) begin errors++; $display("FAIL reset_clk got %b want 0", a.clk); end
    checks++; if (a.rise !== 1'b0) begin errors++; $display("FAIL reset_rise got %b want 0", a.rise); end
    checks++; if (a.fall !== 1'b0) begin errors++; $display("FAIL reset_fall got %b want 0", a.fall); end
    checks++; if (a.ack  !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", a.ack); end
    checks++; if (a.err  !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", a.err); end
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a.busy); end
    checks++; if (a.cur  !== 8'd8) begin errors++; $display("FAIL reset_cur got %0d want 8", a.cur); end
    @(negedge CLK);
    RST_N = 1'b1;
    push_idle(0, 0, 8);
    push_idle(0, 0, 8);
    run_n(2, -1, 0, -1, 0, -1, -1);
  endtask

  task automatic test_run();
    test_name = "run_div8";
    iRUN = 1'b1;
    push_period(8, 1, 0, 0);
    push_period(8, 0, 0, 0);
    push_period(8, 0, 0, 0);
    run_n(24, -1, 0, -1, 0, -1, -1);
  endtask

  task automatic test_ratio_change();
    test_name = "ratio_8_to_5";
    push_period(8, 0, 0, 0);
    push_period(5, 0, 1, 0);
    push_period(5, 0, 0, 0);
    run_n(18, 2, 8'd5, -1, 0, -1, -1);
  endtask

  task automatic test_last_wins();
    test_name = "last_wins";
    push_period(5, 0, 0, 0);
    push_period(10, 0, 1, 0);
    push_period(10, 0, 0, 0);
    run_n(25, 0, 8'd6, 2, 8'd10, -1, -1);
  endtask

  task automatic test_reject();
    test_name = "reject";
    push_period(10, 0, 0, 32'h14);
    push_period(10, 0, 0, 0);
    run_n(20, 1, 8'd1, 3, 8'd0, -1, -1);
  endtask

  task automatic test_boundary_req();
    test_name = "boundary_req";
    push_period(10, 0, 0, 0);
    push_period(10, 0, 0, 0);
    push_period(6, 0, 1, 0);
    run_n(26, 9, 8'd6, -1, 0, -1, -1);
  endtask

  task automatic test_drain_apply();
    test_name = "drain_apply";
    push_period(6, 0, 0, 0);
    push_idle(1, 1, 8);
    push_idle(0, 0, 8);
    push_idle(0, 0, 8);
    run_n(9, 1, 8'd8, -1, 0, 3, -1);
  endtask

  task automatic test_reraise();
    test_name = "reraise";
    iRUN = 1'b1;
    push_period(8, 1, 0, 0);
    push_period(8, 0, 0, 0);
    push_period(8, 0, 0, 0);
    run_n(24, -1, 0, -1, 0, 10, 13);
  endtask

  task automatic test_drain();
    test_name = "drain";
    push_period(8, 0, 0, 0);
    push_period(8, 0, 0, 0);
    push_idle(1, 0, 8);
    push_idle(0, 0, 8);
    run_n(18, -1, 0, -1, 0, 13, -1);
  endtask

  task automatic test_idle_apply();
    test_name = "idle_apply";
    iDIV_REQ = 1'b1;
    iDIV_VAL = 8'd7;
    push_idle(0, 0, 8);
    push_idle(0, 1, 7);
    push_idle(0, 0, 7);
    run_n(3, -1, 0, -1, 0, -1, -1);
  endtask

  task automatic test_reset_mid();
    exp_t a;
    test_name = "reset_mid";
    iRUN = 1'b1;
    push_period(7, 1, 0, 0);
    run_n(7, 1, 8'd3, -1, 0, -1, -1);
    #2;
    RST_N = 1'b0;
    #1;
    a = actual();
    checks++;
    if (a !== exp_t'({6'b000000, 8'd8})) begin
      errors++;
      $display("FAIL reset_mid_async got clk/rise/fall/ack/err/busy=%b cur=%0d, want 000000 cur=8",
               a[13:8], a.cur);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    push_period(8, 1, 0, 0);
    push_period(8, 0, 0, 0);
    run_n(16, -1, 0, -1, 0, 15, -1);
  endtask

  initial begin
    test_reset();
    test_run();
    test_ratio_change();
    test_last_wins();
    test_reject();
    test_boundary_req();
    test_drain_apply();
    test_reraise();
    test_drain();
    test_idle_apply();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got %0d entries want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Runtime-programmable clock-divider controller for the camera/sensor clock path.
- Sequences start/stop of a divided clock level and accepts divide-ratio changes over a req/ack handshake.
- New ratios are applied only at period boundaries, so the output never produces a runt pulse.
- oDIV_CLK is a registered level intended to drive a global clock buffer outside this block.
- Phase strobes let CLK-domain logic act on the divided clock's edges without crossing domains.

Parameters:
- CNT_W, 8, width of the divide-ratio value and of the period counter.
- DEF_DIV, 8, divide ratio loaded at reset; legal range is 2..2^CNT_W-1.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- iRUN  in  1  level; 1 = generate divided clock, 0 = stop at the end of the current period.
- iDIV_REQ  in  1  one-cycle request to change the ratio.
- iDIV_VAL  in  CNT_W  requested ratio, sampled when iDIV_REQ=1.
- oDIV_ACK  out  1  one-cycle pulse when the pending ratio becomes active.
- oDIV_ERR  out  1  one-cycle pulse when a request is rejected.
- oDIV_CLK  out  1  registered divided clock level.
- oRISE_STB  out  1  one-cycle pulse in the first CLK cycle where oDIV_CLK=1.
- oFALL_STB  out  1  one-cycle pulse in the first CLK cycle where oDIV_CLK=0 after a high phase.
- oBUSY  out  1  1 in RUN and DRAIN states.
- oCUR_DIV  out  CNT_W  currently active ratio.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N; all state is cleared the instant RST_N=0, including mid-period.
- Reset values:
  - State IDLE, cnt=0, active_div=DEF_DIV, pending_valid=0.
  - oDIV_CLK, oDIV_ACK, oDIV_ERR, oRISE_STB, oFALL_STB and oBUSY are all 0.
  - oCUR_DIV=DEF_DIV.
- Waveform:
  - cnt runs 0..active_div-1 and then wraps to 0.
  - oDIV_CLK is registered with cnt and equals (cnt >= active_div>>1).
  - Low phase is floor(div/2) cycles; high phase is div-floor(div/2) cycles; period is div cycles.
- Strobes (all registered, aligned to the oDIV_CLK transition cycle):
  - oRISE_STB=1 in the cycle where cnt == active_div>>1.
  - oFALL_STB=1 in the cycle where cnt wraps to 0 from active_div-1, in RUN or DRAIN.
  - oFALL_STB is never asserted on the first period after leaving IDLE.
- FSM:
  - IDLE:
    - cnt is held at 0 and oDIV_CLK=0.
    - iRUN=1 -> RUN. The next cycle has cnt=0 and begins the low phase.
  - RUN:
    - cnt increments every cycle.
    - iRUN=0 -> DRAIN. The current period always completes.
  - DRAIN:
    - cnt continues to increment.
    - iRUN=1 -> RUN, with no disturbance to cnt.
    - At cnt==active_div-1 with iRUN=0 -> IDLE. The next cycle has cnt=0, oDIV_CLK=0 and oFALL_STB=1 (the final falling edge).
- Ratio handshake:
  - A request with iDIV_VAL<2 is rejected: oDIV_ERR pulses the next cycle and the pending register is unchanged.
  - A legal request loads pending_div and sets pending_valid. If a value is already pending it is overwritten (last wins), and only one ack is issued.
  - Apply point in IDLE: the request is applied in the cycle after capture; oDIV_ACK pulses in that same cycle.
  - Apply point in RUN/DRAIN: applied at the period boundary, i.e. on the cycle where cnt==active_div-1 and pending_valid was already 1 at the start of that cycle.
    - cnt wraps to 0 under the new ratio.
    - oDIV_ACK pulses and oCUR_DIV updates in the cycle cnt=0.
  - A request arriving in the boundary cycle itself waits for the next boundary.
- Simultaneous events at a boundary: ratio apply and DRAIN->IDLE both take effect together. The new ratio is active when the block re-enters RUN.
- Width rules:
  - cnt is CNT_W bits.
  - The comparison uses active_div-1 computed in CNT_W bits.
  - The legal range guarantees no underflow.

Decomposition:
- Package clk_div_pkg holds:
  - state enum ST_IDLE, ST_RUN, ST_DRAIN;
  - constant MIN_DIV=2.
- One sub-module is natural: clk_div_core, containing cnt, the oDIV_CLK register and the strobe generation, driven by active_div and a run enable.
- The FSM and the handshake stay in the top-level block.

Test Plan:
- Reset, then iRUN=1 with DEF_DIV=8 -> oDIV_CLK is 4 low / 4 high; oRISE_STB every 8 cycles at cnt=4; oFALL_STB first appears 8 cycles after the first cnt=0.
- In RUN, request iDIV_VAL=5 at cnt=2 -> current period finishes at 8 cycles; oDIV_ACK pulses with oCUR_DIV=5; next periods are 2 low / 3 high.
- Requests 6 then 10 before the boundary -> exactly one oDIV_ACK; oCUR_DIV=10; period is 10.
- iDIV_VAL=1 and iDIV_VAL=0 -> oDIV_ERR pulses one cycle later; oCUR_DIV and period unchanged; no ack.
- iRUN=0 at cnt=5 (div=8) -> oBUSY stays 1 through cnt=7, then IDLE with oDIV_CLK=0; no truncated high phase. Re-raising iRUN during DRAIN gives a seamless waveform.
- RST_N=0 mid-high-phase -> all outputs 0 immediately; oCUR_DIV=8; pending request discarded.
